fpu_add_sub_swap_align: RTL
===========================

// Module: fpu_add_sub_swap_align
// PURPOSE
//  Operand swap/align stage of FPU_ADD_SUB: consumes two IEEE-754 single operands and orders them by magnitude.
//  Exponent order comes from an ADD_SUB_COMP_8bit instance; mantissa order breaks exponent ties.
//  Right-shifts the smaller mantissa by the exponent difference with guard/round/sticky bits.
//  Feeds the mantissa add/sub stage. 2-stage valid/ready pipeline, full throughput.
// PARAMETERS
//  EXP_W   8   exponent width (only default verified)
//  MAN_W   23  stored fraction width
//  GRS_W   3   guard/round/sticky bits appended below the mantissa
// PORTS
//  i_clk        in   1   clock, rising edge
//  i_rst_n      in   1   asynchronous reset, active-low
//  i_valid      in   1   input operands valid
//  o_ready      out  1   stage can accept this cycle
//  i_data_a     in   32  operand A
//  i_data_b     in   32  operand B
//  i_op_sub     in   1   1 = A-B, 0 = A+B
//  o_valid      out  1   aligned result valid
//  i_ready      in   1   downstream accepts
//  o_swap       out  1   1 = |B|>|A|, operands exchanged
//  o_sign_big   out  1   sign of larger-magnitude operand (B's sign inverted when i_op_sub=1)
//  o_eff_sub    out  1   effective subtraction = sign_a ^ sign_b ^ i_op_sub
//  o_exp        out  8   effective exponent of larger operand
//  o_mant_big   out  27  {hidden, frac, 3'b000} of larger operand
//  o_mant_small out  27  smaller mantissa, aligned, LSB = sticky
//  o_special    out  1   either operand has exp==8'hFF; data still computed
// BEHAVIOUR
//  Reset (async, i_rst_n=0): s1_valid=s2_valid=0 -> o_valid=0, all data regs 0, o_ready=1 after release.
//  Handshake: adv2 = i_ready | ~s2_valid; adv1 = adv2 | ~s1_valid; o_ready = adv1 (combinational).
//  Transfer in on i_valid&o_ready; out on o_valid&i_ready. Outputs held stable while o_valid&~i_ready.
//  Latency: 2 cycles accept->o_valid with no stall; back-to-back accepts sustain 1/cycle.
//  Stage 1 (register on adv1):
//   - hidden = (exp!=0); effective exp = (exp==0) ? 1 : exp (denormals).
//   - swap = exp_b>exp_a (comparator) | (exp equal & frac_b>frac_a). Equal magnitudes: swap=0.
//   - register big/small fields and diff = exp_big - exp_small (8-bit, never negative).
//  Stage 2 (register on adv2):
//   - m = {hidden_s, frac_s, 3'b000}; sh = min(diff,27).
//   - o_mant_small = (m>>sh) | (OR of bits shifted out) in bit 0.
//   - diff>=27 -> o_mant_small = {26'b0, |m}.
//   - diff=0 -> o_mant_small = m unchanged.
//   - o_mant_big, o_exp, signs, o_special pass through from stage 1.
//  s1_valid/s2_valid clear when their slot empties and nothing refills it.
//  Simultaneous accept and emit in the same cycle is legal.
//  Reset mid-operation drops in-flight data; no partial output.
// TESTING
//  1 A=0x40400000 B=0x3F800000 add -> swap=0 exp=128 mant_big=0x6000000 mant_small=0x2000000 eff_sub=0
//  2 A=0x3F800000 B=0x40400000 add -> swap=1 exp=128 mant_big=0x6000000 mant_small=0x2000000 sign_big=0
//  3 A=0x3F800000 B=0x3FC00000 sub -> tie broken by frac: swap=1 exp=127 sign_big=1 eff_sub=1 mant_small=0x4000000
//  4 A=0x4B800000 B=0x3F800001 (diff 24) -> mant_small=0x0000005; A=0x53800000 B=0x3F800000 (diff 40) -> 0x0000001
//  5 hold i_ready=0, offer 3 ops -> 2 accepted, o_ready=0, o_valid=1 with op1 stable; release -> ops 1,2,3 in order, none lost
//  6 A=0x7F800000 -> o_special=1; assert i_rst_n=0 with both stages full -> o_valid=0 at once, first output after reset is the new op

Source files
------------

// File: rtl/fpu_add_sub_swap_align_if.sv
// Purpose: handshake and data bundle between the swap/align stage and its neighbours.
// Latency: none, wires only.
// Backpressure: carries i_ready from downstream and o_ready back upstream.
interface fpu_add_sub_swap_align_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int GRS_W = 3
);
    localparam int DW = 1 + EXP_W + MAN_W;
    localparam int MW = 1 + MAN_W + GRS_W;

    logic             i_valid;
    logic             o_ready;
    logic [DW-1:0]    i_data_a;
    logic [DW-1:0]    i_data_b;
    logic             i_op_sub;
    logic             o_valid;
    logic             i_ready;
    logic             o_swap;
    logic             o_sign_big;
    logic             o_eff_sub;
    logic [EXP_W-1:0] o_exp;
    logic [MW-1:0]    o_mant_big;
    logic [MW-1:0]    o_mant_small;
    logic             o_special;

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_op_sub, i_ready,
        output o_ready, o_valid, o_swap, o_sign_big, o_eff_sub,
               o_exp, o_mant_big, o_mant_small, o_special
    );

    modport master (
        output i_valid, i_data_a, i_data_b, i_op_sub, i_ready,
        input  o_ready, o_valid, o_swap, o_sign_big, o_eff_sub,
               o_exp, o_mant_big, o_mant_small, o_special
    );
endinterface

// File: rtl/fpu_add_sub_swap_align.sv
// Purpose: order two IEEE-754 operands by magnitude and right-align the smaller mantissa with GRS bits.
// Latency: 2 cycles accept to o_valid, one operation per cycle sustained.
// Backpressure: each stage advances when the one after it is empty or draining; o_ready is combinational.

// 8-bit magnitude comparator: a_i > b_i, equality, and |a_i - b_i|.
module add_sub_comp_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic       a_gt_b_o,
    output logic       a_eq_b_o,
    output logic [7:0] abs_diff_o
);
    logic [8:0] sub_ab;
    logic [7:0] sub_ba;

    // Borrow out of a-b says b is larger; the opposite subtraction gives the magnitude then.
    always_comb begin
        sub_ab     = {1'b0, a_i} - {1'b0, b_i};
        sub_ba     = b_i - a_i;
        a_eq_b_o   = (sub_ab[7:0] == 8'd0) && !sub_ab[8];
        a_gt_b_o   = !sub_ab[8] && !a_eq_b_o;
        abs_diff_o = sub_ab[8] ? sub_ba : sub_ab[7:0];
    end
endmodule

module fpu_add_sub_swap_align #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int GRS_W = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    fpu_add_sub_swap_align_if.slave  bus
);
    localparam int MW   = 1 + MAN_W + GRS_W;
    localparam int SH_W = $clog2(MW + 1);
    localparam logic [EXP_W-1:0] MW_E  = EXP_W'(MW);
    localparam logic [SH_W-1:0]  MW_S  = SH_W'(MW);
    localparam logic [EXP_W-1:0] EXP_1 = EXP_W'(1);

    // Handshake: a slot may load when its successor can take its current content.
    logic adv1, adv2;
    logic s1_valid_q, s2_valid_q;

    assign adv2        = bus.i_ready | ~s2_valid_q;
    assign adv1        = adv2 | ~s1_valid_q;
    assign bus.o_ready = adv1;
    assign bus.o_valid = s2_valid_q;

    // Stage 1 combinational decode and ordering.
    logic             sa, sb, sb_eff;
    logic [EXP_W-1:0] exa, exb, ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             ha, hb;
    logic             b_gt_a_exp, exp_eq, swap;
    logic [EXP_W-1:0] diff;

    add_sub_comp_8bit u_exp_cmp (
        .a_i        (eb),
        .b_i        (ea),
        .a_gt_b_o   (b_gt_a_exp),
        .a_eq_b_o   (exp_eq),
        .abs_diff_o (diff)
    );

    // Unpack fields; denormals use exponent 1 with no hidden bit so the comparison stays in magnitude order.
    always_comb begin
        sa     = bus.i_data_a[EXP_W+MAN_W];
        sb     = bus.i_data_b[EXP_W+MAN_W];
        exa    = bus.i_data_a[MAN_W +: EXP_W];
        exb    = bus.i_data_b[MAN_W +: EXP_W];
        fa     = bus.i_data_a[MAN_W-1:0];
        fb     = bus.i_data_b[MAN_W-1:0];
        ha     = (exa != '0);
        hb     = (exb != '0);
        ea     = ha ? exa : EXP_1;
        eb     = hb ? exb : EXP_1;
        sb_eff = sb ^ bus.i_op_sub;
        swap   = b_gt_a_exp | (exp_eq & ({hb, fb} > {ha, fa}));
    end

    logic             s1_swap_q, s1_sign_big_q, s1_eff_sub_q, s1_special_q, s1_hid_s_q;
    logic [EXP_W-1:0] s1_exp_q, s1_diff_q;
    logic [MW-1:0]    s1_mant_big_q;
    logic [MAN_W-1:0] s1_frac_s_q;

    // Stage 1 register: capture ordered operands when the slot advances with a new operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_swap_q     <= 1'b0;
            s1_sign_big_q <= 1'b0;
            s1_eff_sub_q  <= 1'b0;
            s1_special_q  <= 1'b0;
            s1_hid_s_q    <= 1'b0;
            s1_exp_q      <= '0;
            s1_diff_q     <= '0;
            s1_mant_big_q <= '0;
            s1_frac_s_q   <= '0;
        end else if (adv1) begin
            s1_valid_q <= bus.i_valid;
            if (bus.i_valid) begin
                s1_swap_q     <= swap;
                s1_sign_big_q <= swap ? sb_eff : sa;
                s1_eff_sub_q  <= sa ^ sb ^ bus.i_op_sub;
                s1_special_q  <= (exa == '1) | (exb == '1);
                s1_exp_q      <= swap ? eb : ea;
                s1_diff_q     <= diff;
                s1_mant_big_q <= swap ? {hb, fb, {GRS_W{1'b0}}} : {ha, fa, {GRS_W{1'b0}}};
                s1_hid_s_q    <= swap ? ha : hb;
                s1_frac_s_q   <= swap ? fa : fb;
            end
        end
    end

    // Stage 2 alignment: shift into a double-width window so the low half holds everything shifted out.
    logic [SH_W-1:0] sh;
    logic [MW-1:0]   m_small;
    logic [2*MW-1:0] win;
    logic [MW-1:0]   aligned;

    always_comb begin
        m_small = {s1_hid_s_q, s1_frac_s_q, {GRS_W{1'b0}}};
        sh      = (s1_diff_q >= MW_E) ? MW_S : s1_diff_q[SH_W-1:0];
        win     = {m_small, {MW{1'b0}}} >> sh;
        aligned = win[2*MW-1:MW] | {{(MW-1){1'b0}}, |win[MW-1:0]};
    end

    logic             s2_swap_q, s2_sign_big_q, s2_eff_sub_q, s2_special_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [MW-1:0]    s2_mant_big_q, s2_mant_small_q;

    // Stage 2 register: outputs hold while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid_q      <= 1'b0;
            s2_swap_q       <= 1'b0;
            s2_sign_big_q   <= 1'b0;
            s2_eff_sub_q    <= 1'b0;
            s2_special_q    <= 1'b0;
            s2_exp_q        <= '0;
            s2_mant_big_q   <= '0;
            s2_mant_small_q <= '0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_swap_q       <= s1_swap_q;
                s2_sign_big_q   <= s1_sign_big_q;
                s2_eff_sub_q    <= s1_eff_sub_q;
                s2_special_q    <= s1_special_q;
                s2_exp_q        <= s1_exp_q;
                s2_mant_big_q   <= s1_mant_big_q;
                s2_mant_small_q <= aligned;
            end
        end
    end

    assign bus.o_swap       = s2_swap_q;
    assign bus.o_sign_big   = s2_sign_big_q;
    assign bus.o_eff_sub    = s2_eff_sub_q;
    assign bus.o_special    = s2_special_q;
    assign bus.o_exp        = s2_exp_q;
    assign bus.o_mant_big   = s2_mant_big_q;
    assign bus.o_mant_small = s2_mant_small_q;
endmodule
